prescaled_counter: RTL
======================

# prescaled_counter

Parametrised modulo-N up/down counter driven by an internal prescaler tick, the next generation of the board-level blink/ripple counter pair. A clock-enable tick replaces the derived divided clock, so the whole block runs on the single system clock. It adds direction control, synchronous load, a programmable modulus and a terminal-count pulse. It sits between the board clock and LED/display logic as the general-purpose slow counter.

## Interface
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range 0..MODULUS-1, with 2 ≤ MODULUS ≤ 2**WIDTH.
- PRESCALE, 25_000_000: system-clock cycles per count step, ≥ 1.

Ports:
- clock_in  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = prescaler and counter advance; 0 = both hold.
- up_down  input  1  1 = count up, 0 = count down; sampled on tick cycles.
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value loaded when load = 1.
- q  output  WIDTH  registered count.
- tick  output  1  prescaler step strobe (combinational decode).
- terminal  output  1  registered one-cycle wrap/boundary pulse.

## Operation
- Prescaler `pre` is $clog2(PRESCALE) bits wide, with a minimum of 1.
  - Counts 0..PRESCALE-1 while enable = 1, then wraps to 0.
  - tick = enable && (pre == PRESCALE-1).
  - With PRESCALE = 1, tick = enable on every cycle.
- Priority per edge: reset > load > tick > hold.
- Load:
  - q ← min(load_value, MODULUS-1); pre ← 0; terminal ← 0.
  - Load takes effect independent of enable and tick.
  - A tick in the same cycle as load is discarded.
- Tick with up_down = 1: if q == MODULUS-1, then q ← 0 and terminal ← 1; otherwise q ← q+1.
- Tick with up_down = 0: if q == 0, then q ← MODULUS-1 and terminal ← 1; otherwise q ← q-1.
- No tick: q holds and terminal ← 0.
- enable = 0 freezes pre and q with no phase loss; counting resumes at the same prescaler phase.
- Arithmetic is done in WIDTH bits and compares against MODULUS-1 only. Values ≥ MODULUS are unreachable because load clamps.

## Timing
- Reset values: q = 0, pre = 0, terminal = 0. tick = 0 while reset = 0, because it decodes pre = 0 (PRESCALE > 1) and gates with enable.
- Reset acts asynchronously: q clears without a clock edge.
- Reset deassertion is synchronous to the next clock_in edge. The first tick occurs in the PRESCALE-th enabled cycle after release.
- q changes on the rising edge that ends a tick cycle, giving a 1-cycle latency from tick to q.
- terminal is high for exactly the one cycle following that edge, aligned with the wrapped q value.
- Load is visible on q at the edge after load is sampled. The next step follows PRESCALE enabled cycles later.
- A mid-operation reset aborts any step in flight. The tick decode is dropped immediately.

## Configuration
- CNT_SATURATE_EN defined: at a boundary tick (MODULUS-1 going up, 0 going down), q holds instead of wrapping. terminal still pulses on every such boundary tick.
- CNT_SATURATE_EN undefined: modulo wrap as described in Operation.

## Structure
- Package counter_pkg:
  - direction constants CNT_UP = 1'b1, CNT_DOWN = 1'b0;
  - helper function for prescaler width (clog2 with a minimum of 1).
- Sub-module tick_prescaler contains the enable-gated divider.
  - Parameter: PRESCALE.
  - Ports: clock_in, reset, enable, clear, tick.
  - The parent drives clear from load.
- The top-level counter register, load clamp and terminal register live in prescaled_counter.

## Test plan
All scenarios use WIDTH = 4, MODULUS = 10, PRESCALE = 4 unless noted.
- Reset held low, clock running, enable = 1 → q = 0, tick = 0, terminal = 0 throughout. Drop reset mid-count at q = 6 → q = 0 before the next edge.
- Release reset, enable = 1, up_down = 1 → tick every 4th cycle; q counts 1..9, then 0 after 40 cycles, with terminal high for exactly 1 cycle alongside q = 0.
- From q = 0 with up_down = 0 → first step gives q = 9 with a terminal pulse. With CNT_SATURATE_EN, q stays 0 and terminal still pulses.
- Loads:
  - load = 1 with load_value = 7 at prescaler phase 2 → q = 7 next edge; next increment to 8 exactly 4 cycles later.
  - load_value = 12 → q = 9.
  - load and tick in the same cycle → q = load value.
- enable = 0 for 10 cycles at phase 2, q = 3 → q and tick frozen. After re-enable, q = 4 after 2 more cycles.
- PRESCALE = 1, MODULUS = 16 → q increments every cycle and wraps 15→0 with terminal pulses 16 cycles apart.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the prescaled counter slice.
// Optional saturation mode is selected with CNT_SATURATE_EN (see prescaled_counter).
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Prescaler register width: clog2 of the division ratio, never narrower than 1 bit.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated divider producing a one-cycle step strobe every PRESCALE enabled cycles.
// clear restarts the phase at 0 so a load is followed by a full step interval.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 25_000_000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int             PW       = pre_width(PRESCALE);
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end

  // Gating with reset keeps the strobe low during reset even when PRESCALE is 1.
  assign tick = reset & enable & (pre == PRE_LAST);

endmodule

// File: rtl/prescaled_counter.sv
// Modulo-MODULUS up/down counter stepped by an internal prescaler tick, with clamped load
// and a terminal-count pulse. Define CNT_SATURATE_EN to hold at the boundary instead of wrapping.
module prescaled_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 25_000_000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULUS - 1);

  logic             boundary;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] q_step;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock_in (clock_in),
    .reset    (reset),
    .enable   (enable),
    .clear    (load),
    .tick     (tick)
  );

  always_comb begin
    boundary     = (up_down == CNT_UP) ? (q == Q_LAST) : (q == '0);
    load_clamped = (load_value > Q_LAST) ? Q_LAST : load_value;
    q_step       = q;
`ifdef CNT_SATURATE_EN
    if (!boundary) begin
      q_step = (up_down == CNT_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
    end
`else
    if (boundary) begin
      q_step = (up_down == CNT_UP) ? '0 : Q_LAST;
    end else begin
      q_step = (up_down == CNT_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
    end
`endif
  end

  // Load outranks a coincident tick; that tick's step and terminal are discarded.
  always_ff @(posedge clock_in or negedge reset) begin
    if (!reset) begin
      q        <= '0;
      terminal <= 1'b0;
    end else if (load) begin
      q        <= load_clamped;
      terminal <= 1'b0;
    end else if (tick) begin
      q        <= q_step;
      terminal <= boundary;
    end else begin
      terminal <= 1'b0;
    end
  end

endmodule
